// File: rtl/lab3_input_conditioner.sv
// ---------------------------------------------------------------------------
// lab3_input_conditioner
//
// Conditions the raw board slide switches and push button before they reach
// lab2_mux2. Each input passes through a two-flop synchroniser and then a
// counter-based debouncer. A new level is accepted only after it has been
// seen, post-synchroniser, for DEBOUNCE_CYCLES consecutive clocks. Every
// output comes from a flop, so no raw input reaches an output
// combinationally.
//
// Optional feature (macro CTRL_TOGGLE_EN):
//   defined   : ctrl_out is a toggle flop that flips on every btn_pulse.
//   undefined : ctrl_out follows the debounced button level.
//
// Parameters:
//   WIDTH            number of select switches (drives mux s)
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a level (>= 1)
//
// Ports:
//   clk        in   system clock (100 MHz)
//   reset_n    in   asynchronous active-low reset, synchronous release
//   sw_in      in   raw slide switches [WIDTH-1:0]
//   btn_in     in   raw push button
//   s_out      out  debounced switch levels [WIDTH-1:0], to mux s
//   ctrl_out   out  control level, to mux ctrl
//   btn_pulse  out  one-cycle pulse on each accepted button press
// ---------------------------------------------------------------------------
module lab3_input_conditioner #(
   parameter int WIDTH           = 2,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] sw_in,
   input  logic             btn_in,
   output logic [WIDTH-1:0] s_out,
   output logic             ctrl_out,
   output logic             btn_pulse
);

   // Channels 0..WIDTH-1 are the switches. Channel WIDTH is the button.
   localparam int NCH = WIDTH + 1;
   localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [NCH-1:0]         raw;
   logic [NCH-1:0]         sync_a;
   logic [NCH-1:0]         sync_b;
   logic [NCH-1:0]         stable;
   logic [NCH-1:0][CW-1:0] cnt;
   logic                   btn_prev;

   assign raw = {btn_in, sw_in};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
      end
   end

   // The counter holds the number of consecutive cycles on which the synced
   // level has differed from the accepted level. Any return to the accepted
   // level clears it. The counter stops at CNT_LAST, so it can never wrap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable <= '0;
         cnt    <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (sync_b[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               stable[i] <= sync_b[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   // The pulse fires on the cycle after the debounced button rises.
   // A release produces no pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         btn_prev  <= 1'b0;
         btn_pulse <= 1'b0;
      end else begin
         btn_prev  <= stable[WIDTH];
         btn_pulse <= stable[WIDTH] & ~btn_prev;
      end
   end

   assign s_out = stable[WIDTH-1:0];

`ifdef CTRL_TOGGLE_EN
   logic ctrl_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q <= 1'b0;
      end else if (btn_pulse) begin
         ctrl_q <= ~ctrl_q;
      end
   end

   assign ctrl_out = ctrl_q;
`else
   assign ctrl_out = stable[WIDTH];
`endif

endmodule

// File: tb/tb_lab3_input_conditioner.sv
module tb_lab3_input_conditioner;

   localparam int W   = 2;
   localparam int D   = 4;
   localparam int NCH = W + 1;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [W-1:0] sw_in;
   logic         btn_in;
   logic [W-1:0] s_out;
   logic         ctrl_out;
   logic         btn_pulse;

   int checks = 0;
   int errors = 0;
   int npulse = 0;

   // Reference model state: the raw input sampled at each live clock edge,
   // with the newest sample at the back, plus the accepted levels.
   logic [NCH-1:0] hist[$];
   logic [NCH-1:0] m_st;
   logic           m_prev;
   logic           m_pulse;
   logic           m_ctrl;

   lab3_input_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .sw_in     (sw_in),
      .btn_in    (btn_in),
      .s_out     (s_out),
      .ctrl_out  (ctrl_out),
      .btn_pulse (btn_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hist = {};
      for (int i = 0; i < D + 2; i++) hist.push_back('0);
      m_st    = '0;
      m_prev  = 1'b0;
      m_pulse = 1'b0;
      m_ctrl  = 1'b0;
   endtask

   // A level is accepted once the synchronised value, which is the raw input
   // from two edges earlier, has disagreed with the accepted level on each of
   // the last D edges.
   task automatic model_edge();
      logic old_b, new_pulse, all_diff;
      int   idx;
      if (!reset_n) begin
         model_reset();
         return;
      end
      hist.push_back({btn_in, sw_in});
      if (hist.size() > D + 6) void'(hist.pop_front());
      old_b     = m_st[W];
      new_pulse = old_b & ~m_prev;
      m_prev    = old_b;
`ifdef CTRL_TOGGLE_EN
      if (m_pulse) m_ctrl = ~m_ctrl;
`endif
      for (int ch = 0; ch < NCH; ch++) begin
         all_diff = 1'b1;
         for (int j = 0; j < D; j++) begin
            idx = hist.size() - 3 - j;
            if (hist[idx][ch] == m_st[ch]) all_diff = 1'b0;
         end
         if (all_diff) m_st[ch] = ~m_st[ch];
      end
      m_pulse = new_pulse;
`ifndef CTRL_TOGGLE_EN
      m_ctrl = m_st[W];
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("s_out", 32'(s_out), 32'(m_st[W-1:0]));
      chk("ctrl_out", 32'(ctrl_out), 32'(m_ctrl));
      chk("btn_pulse", 32'(btn_pulse), 32'(m_pulse));
      if (btn_pulse) npulse++;
   endtask

   task automatic async_reset();
      #3;
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("async_rst_s", 32'(s_out), 32'd0);
      chk("async_rst_ctrl", 32'(ctrl_out), 32'd0);
      chk("async_rst_pulse", 32'(btn_pulse), 32'd0);
   endtask

   initial begin
      int hold;
      bit exp_ctrl;

      reset_n = 1'b0;
      sw_in   = 2'b11;
      btn_in  = 1'b1;
      model_reset();

      // Outputs stay at zero while reset is held, even with all inputs high.
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("rst_hold_s", 32'(s_out), 32'd0);
         chk("rst_hold_ctrl", 32'(ctrl_out), 32'd0);
         chk("rst_hold_pulse", 32'(btn_pulse), 32'd0);
      end
      sw_in   = 2'b00;
      btn_in  = 1'b0;
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) tick();

      // After a clean switch change, the new level appears on exactly the
      // sixth edge.
      sw_in = 2'b10;
      for (int k = 0; k <= 5; k++) begin
         tick();
         chk("clean_latency", 32'(s_out), (k == 5) ? 32'h2 : 32'h0);
      end

      // A bouncing switch bit is rejected, and a sustained level is accepted.
      for (int i = 0; i < 12; i++) begin
         sw_in = {1'b1, ~i[0]};
         tick();
         chk("bounce_reject", 32'(s_out[0]), 32'd0);
      end
      sw_in = 2'b10;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("bounce_settle", 32'(s_out[0]), 32'd0);
      end
      sw_in = 2'b11;
      for (int i = 0; i < 8; i++) tick();
      chk("bounce_accept", 32'(s_out), 32'h3);

      // Two press/release rounds, each producing a single pulse.
      exp_ctrl = 1'b0;
      for (int r = 0; r < 2; r++) begin
         npulse = 0;
         btn_in = 1'b1;
         for (int i = 0; i < 20; i++) tick();
         chk("press_pulses", 32'(npulse), 32'd1);
`ifdef CTRL_TOGGLE_EN
         exp_ctrl = ~exp_ctrl;
         chk("press_ctrl", 32'(ctrl_out), 32'(exp_ctrl));
`else
         chk("press_ctrl", 32'(ctrl_out), 32'd1);
`endif
         npulse = 0;
         btn_in = 1'b0;
         for (int i = 0; i < 12; i++) tick();
         chk("release_pulses", 32'(npulse), 32'd0);
`ifdef CTRL_TOGGLE_EN
         chk("release_ctrl", 32'(ctrl_out), 32'(exp_ctrl));
`else
         chk("release_ctrl", 32'(ctrl_out), 32'd0);
`endif
      end
      chk("two_press_ctrl", 32'(ctrl_out), 32'd0);

      // A reset partway through a count discards the partial count.
      btn_in = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      async_reset();
      tick();
      reset_n = 1'b1;
      npulse = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (k < 6) chk("rst_mid_nopulse", 32'(btn_pulse), 32'd0);
      end
      chk("rst_mid_pulses", 32'(npulse), 32'd1);

      // Randomized holds of 1..7 cycles, with occasional resets.
      hold = 0;
      for (int i = 0; i < 500; i++) begin
         if (hold == 0) begin
            sw_in  = W'($urandom);
            btn_in = 1'($urandom);
            hold   = $urandom_range(1, 7);
         end
         hold--;
         if ($urandom_range(0, 149) == 0) begin
            async_reset();
            tick();
            tick();
            reset_n = 1'b1;
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
